pwm_peripheral: RTL
===================

Name: pwm_peripheral

Overview:
Consumes the five configuration bytes written over SPI and drives the 16 chip outputs. Each output is static-low, static-high or PWM-modulated, selected by the output-enable and PWM-enable registers. A single shared 8-bit PWM waveform is produced from a clock prescaler and period counter. The duty cycle is double-buffered so it only changes on period boundaries.

Parameters:
PRESCALE, 12, clk cycles per PWM count step; legal range 1..65535. 10 MHz/12/256 ≈ 3.26 kHz PWM.
PRESC_W, 16, prescaler counter width.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
en_reg_out_7_0  in  8  output enable, bits 7:0
en_reg_out_15_8  in  8  output enable, bits 15:8
en_reg_pwm_7_0  in  8  PWM select, bits 7:0
en_reg_pwm_15_8  in  8  PWM select, bits 15:8
pwm_duty_cycle  in  8  requested duty, 0x00..0xFF
uo_out  out  8  outputs 7:0
uio_out  out  8  outputs 15:8
uio_oe  out  8  constant 8'hFF (bidir pins always driven)
period_start  out  1  one-clk pulse on the first clk of each PWM period

Behaviour:
- Reset (async, rst_n=0): prescaler=0, pwm_cnt=0, duty_active=0, uo_out=0, uio_out=0, period_start=0. Outputs drop to 0 without waiting for a clk edge.
- Prescaler:
  - Counts 0..PRESCALE-1. When it reaches PRESCALE-1, it raises `tick` and wraps to 0.
  - PRESCALE=1 gives a tick on every clk.
- pwm_cnt: 8-bit, increments on tick, wraps 255→0. No other modification.
- Shadow load: on tick with pwm_cnt==255, duty_active <= pwm_duty_cycle. The new duty applies from pwm_cnt=0 of the next period.
- period_start: registered; high for exactly one clk, in the same cycle pwm_cnt becomes 0 via wrap. Not asserted on reset release.
- pwm_level (combinational internal):
  - duty_active==0xFF → 1 (full-on special case).
  - Otherwise pwm_cnt < duty_active.
  - Result: duty 0x00 is always low; duty N gives high time of N*PRESCALE clk per 256*PRESCALE-clk period.
- Per bit i in 0..15, with en_out={15_8,7_0} and en_pwm likewise:
  - out[i] = en_out[i] ? (en_pwm[i] ? pwm_level : 1) : 0.
  - en_pwm is ignored when en_out is 0.
- Outputs registered: uo_out=out[7:0], uio_out=out[15:8].
  - Latency is 1 clk from an enable change, or from a pwm_cnt/duty_active change, to the pin.
- Enable register changes take effect immediately (next clk) and are not period-aligned. Only duty is shadowed.
- Simultaneous duty change and wrap tick: the value present on pwm_duty_cycle in the wrap cycle is the one captured.
- Inputs are synchronous to clk (register outputs of the SPI block); no synchronisers.

Decomposition:
- Package pwm_pkg:
  - PWM_CNT_W=8
  - DUTY_FULL=8'hFF
  - PRESCALE_DEFAULT=12
  - function pwm_pin(en_out, en_pwm, level) returning the per-bit select
- Sub-module pwm_timebase (prescaler, pwm_cnt, duty shadow, period_start).
  - Outputs pwm_cnt, duty_active, period_start.
  - pwm_peripheral instantiates it and contains the 16-bit select and output registers.

Test Plan (PRESCALE=4 → period 1024 clk):
1. Assert rst_n=0 with en_out=0xFFFF, en_pwm=0, duty=0x80 → uo_out=uio_out=0x00 during reset. After release, uo_out=uio_out=0xFF one clk after first edge; uio_oe=0xFF throughout.
2. en_out=0x0001, en_pwm=0x0000 → uo_out=0x01, uio_out=0x00 one clk later. Set en_out=0 → uo_out=0x00 next clk.
3. en_out=en_pwm=0xFFFF, duty=0x80 from reset:
   - First period uses duty 0 (all outputs low for 1024 clk).
   - From the first period_start on, every pin is high 512 clk, then low 512 clk, each period.
   - period_start pulses every 1024 clk.
4. duty=0x00 → all PWM pins low for 3 full periods. duty=0xFF → all high for 3 full periods, no single-clk low glitch at wrap.
5. duty=0x40 running; write 0xC0 when pwm_cnt=0x10:
   - Current period stays high 256 clk total.
   - Next period is high 768 clk.
6. Mid-period with pins high, pulse rst_n low between clk edges:
   - Pins go 0 asynchronously.
   - After release, pwm_cnt restarts at 0 and duty_active=0 until the next period_start.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and the per-pin output select for the PWM peripheral.
package pwm_pkg;

  localparam int          PWM_CNT_W        = 8;
  localparam logic [7:0]  DUTY_FULL        = 8'hFF;
  localparam int          PRESCALE_DEFAULT = 12;

  // Disabled pins are low; enabled pins are either static high or follow the PWM level.
  function automatic logic pwm_pin(input logic en_out, input logic en_pwm, input logic level);
    return en_out ? (en_pwm ? level : 1'b1) : 1'b0;
  endfunction

endpackage

// File: rtl/pwm_peripheral_if.sv
// Configuration registers in, pin drives and period marker out.
interface pwm_peripheral_if;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  uo_out, uio_out, uio_oe, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output uo_out, uio_out, uio_oe, period_start
  );
endinterface

// File: rtl/pwm_timebase.sv
// Prescaler, 8-bit period counter and shadowed duty; duty only moves at the 255->0 wrap.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT,
  parameter int PRESC_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           duty_req,
  output logic [PWM_CNT_W-1:0] pwm_cnt,
  output logic [7:0]           duty_active,
  output logic                 period_start
);

  logic [PRESC_W-1:0] presc;
  logic               tick;
  logic               wrap;

  assign tick = (presc == PRESC_W'(PRESCALE - 1));
  assign wrap = tick && (pwm_cnt == {PWM_CNT_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      pwm_cnt      <= '0;
      duty_active  <= '0;
      period_start <= 1'b0;
    end else begin
      presc        <= tick ? '0 : presc + PRESC_W'(1);
      period_start <= wrap;
      if (tick)
        pwm_cnt <= pwm_cnt + PWM_CNT_W'(1);
      // Captured in the wrap cycle so the new duty covers the whole next period.
      if (wrap)
        duty_active <= duty_req;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// Drives 16 pins as static-low, static-high or PWM from the SPI-written enable and duty registers.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT,
  parameter int PRESC_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_peripheral_if.slave  bus
);

  logic [PWM_CNT_W-1:0] pwm_cnt;
  logic [7:0]           duty_active;
  logic                 pwm_level;
  logic [15:0]          en_out;
  logic [15:0]          en_pwm;
  logic [15:0]          pin_sel;
  logic [15:0]          pin_q;

  pwm_timebase #(
    .PRESCALE (PRESCALE),
    .PRESC_W  (PRESC_W)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .duty_req     (bus.pwm_duty_cycle),
    .pwm_cnt      (pwm_cnt),
    .duty_active  (duty_active),
    .period_start (bus.period_start)
  );

  assign en_out = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

  // 0xFF is forced fully on; a plain compare would leave one low count per period.
  assign pwm_level = (duty_active == DUTY_FULL) ? 1'b1 : (pwm_cnt < duty_active);

  always_comb begin
    pin_sel = '0;
    for (int i = 0; i < 16; i++)
      pin_sel[i] = pwm_pin(en_out[i], en_pwm[i], pwm_level);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pin_q <= '0;
    else
      pin_q <= pin_sel;
  end

  assign bus.uo_out  = pin_q[7:0];
  assign bus.uio_out = pin_q[15:8];
  assign bus.uio_oe  = 8'hFF;

endmodule
